// File: rtl/uarx_pkg.sv
// Shared definitions for the buffered serial receiver: FSM states, parity
// mode encoding, oversampling constants, receive-buffer entry layout and
// small combinational helpers.
package uarx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } uarx_state_e;

  localparam logic [2:0] PAR_NONE  = 3'd0;
  localparam logic [2:0] PAR_EVEN  = 3'd1;
  localparam logic [2:0] PAR_ODD   = 3'd2;
  localparam logic [2:0] PAR_MARK  = 3'd3;
  localparam logic [2:0] PAR_SPACE = 3'd4;

  localparam int         OVERSAMPLE   = 16;
  localparam logic [3:0] SAMPLE_FIRST = 4'd7;
  localparam logic [3:0] SAMPLE_MID   = 4'd8;
  localparam logic [3:0] SAMPLE_LAST  = 4'd9;

  // Widest supported word; narrower words are zero-extended in an entry.
  localparam int MAX_WIDTH = 9;

  typedef struct packed {
    logic [MAX_WIDTH-1:0] data;
    logic                 framing_err;
    logic                 parity_err;
  } uarx_entry_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic has_parity(input logic [2:0] mode);
    return (mode >= PAR_EVEN) && (mode <= PAR_SPACE);
  endfunction

  // Zero padding above the real word does not disturb the XOR reduction.
  function automatic logic parity_expected(input logic [2:0] mode,
                                           input logic [MAX_WIDTH-1:0] data);
    logic p;
    case (mode)
      PAR_EVEN: p = ^data;
      PAR_ODD:  p = ~^data;
      PAR_MARK: p = 1'b1;
      default:  p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uarx_fifo.sv
// Synchronous show-ahead FIFO: the head entry is visible whenever the FIFO is
// non-empty (zero otherwise). A write while full is accepted only when a read
// happens in the same cycle.
module uarx_fifo #(
  parameter int EntryW = 11,
  parameter int Depth  = 16,
  parameter int CW     = $clog2(Depth) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [EntryW-1:0] wr_data,
  input  logic              rd_en,
  output logic [EntryW-1:0] rd_data,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(Depth);

  logic [EntryW-1:0] mem_r [Depth];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic              do_rd_s;
  logic              do_wr_s;

  assign empty   = (count_r == '0);
  assign full    = (count_r == CW'(Depth));
  assign do_rd_s = rd_en & ~empty;
  assign do_wr_s = wr_en & (~full | do_rd_s);
  assign count   = count_r;
  assign rd_data = empty ? '0 : mem_r[rd_ptr_r];

  // Storage array; contents only matter between write and read pointers.
  always_ff @(posedge clk) begin
    if (do_wr_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers and occupancy move together so count tracks the pointers exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_wr_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_rd_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({do_wr_s, do_rd_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/ua_receiver_buffered.sv
// Buffered asynchronous serial receiver: 16x oversampling with a 7/8/9
// majority vote, runtime divisor and parity mode, per-word error flags,
// break detection and a show-ahead receive buffer with sticky overrun.
// Build option UARX_FIFO_EN: defined -> FifoDepth-entry FIFO;
// undefined -> single holding register (FifoCount is 0 or 1).
module ua_receiver_buffered
  import uarx_pkg::*;
#(
  parameter int Width     = 8,
  parameter int DivWidth  = 16,
  parameter int FifoDepth = 16,
  parameter int FCWidth   = $clog2(FifoDepth) + 1
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [DivWidth-1:0] Divisor,
  input  logic [2:0]          ParityMode,
  input  logic                SIn,
  output logic [Width-1:0]    DataOut,
  output logic                DataOutFramingErr,
  output logic                DataOutParityErr,
  output logic                DataOutValid,
  input  logic                DataOutReady,
  output logic                Overrun,
  input  logic                ClearOverrun,
  output logic                BreakDetect,
  output logic [FCWidth-1:0]  FifoCount
);

  localparam int SampW = $clog2(OVERSAMPLE);

  logic                sync1_r, sync2_r, rx_s;
  logic [DivWidth-1:0] presc_r, div_last_s;
  logic                tick_s, decide_s, vote_s;
  logic [SampW-1:0]    sample_r;
  logic                s7_r, s8_r;
  uarx_state_e         state_r, state_n;
  logic [2:0]          mode_r;
  logic [Width-1:0]    shreg_r;
  logic [3:0]          bit_cnt_r;
  logic                par_bit_r, par_err_r;
  logic                start_s, push_s, break_s, is_break_s;
  uarx_entry_t         push_entry_s, head_s;
  logic                full_s, empty_s, pop_s, overrun_set_s;
  logic                overrun_r, break_r;
  logic [FCWidth-1:0]  count_s;
  logic                unused_s;

  assign rx_s     = sync2_r;
  assign tick_s   = (presc_r >= div_last_s);
  assign decide_s = tick_s & (sample_r == SAMPLE_LAST);
  assign vote_s   = majority3(s7_r, s8_r, rx_s);
  assign is_break_s = ~vote_s & (shreg_r == '0) & ~par_bit_r;
  assign pop_s    = DataOutReady & ~empty_s;
  assign overrun_set_s = push_s & full_s & ~pop_s;

  // Divisor of zero behaves as one.
  always_comb begin
    div_last_s = '0;
    if (Divisor == '0) begin
      div_last_s = '0;
    end else begin
      div_last_s = Divisor - DivWidth'(1);
    end
  end

  // Entry as it would be pushed on the stop-bit decision.
  always_comb begin
    push_entry_s                  = '0;
    push_entry_s.data[Width-1:0]  = shreg_r;
    push_entry_s.framing_err      = ~vote_s;
    push_entry_s.parity_err       = par_err_r;
  end

  // Two-flop synchroniser on the serial line, idling high.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= SIn;
      sync2_r <= sync1_r;
    end
  end

  // Free-running prescaler producing the oversample tick.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      presc_r <= '0;
    end else if (tick_s) begin
      presc_r <= '0;
    end else begin
      presc_r <= presc_r + DivWidth'(1);
    end
  end

  // Oversample index; the start-edge tick counts as sample 0.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sample_r <= '0;
      s7_r     <= 1'b1;
      s8_r     <= 1'b1;
    end else if (tick_s) begin
      sample_r <= start_s ? SampW'(1) : sample_r + SampW'(1);
      if (sample_r == SAMPLE_FIRST) s7_r <= rx_s;
      if (sample_r == SAMPLE_MID)   s8_r <= rx_s;
    end
  end

  // FSM state register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state logic plus the start, push and break strobes.
  always_comb begin
    state_n = state_r;
    start_s = 1'b0;
    push_s  = 1'b0;
    break_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (tick_s && !rx_s) begin
          state_n = ST_START;
          start_s = 1'b1;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_START: begin
        if (decide_s) begin
          state_n = vote_s ? ST_IDLE : ST_DATA;
        end else begin
          state_n = ST_START;
        end
      end
      ST_DATA: begin
        if (decide_s && (bit_cnt_r == 4'(Width - 1))) begin
          state_n = has_parity(mode_r) ? ST_PARITY : ST_STOP;
        end else begin
          state_n = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (decide_s) begin
          state_n = ST_STOP;
        end else begin
          state_n = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (decide_s && is_break_s) begin
          break_s = 1'b1;
          state_n = ST_WAIT_IDLE;
        end else if (decide_s) begin
          push_s  = 1'b1;
          state_n = vote_s ? ST_IDLE : ST_WAIT_IDLE;
        end else begin
          state_n = ST_STOP;
        end
      end
      ST_WAIT_IDLE: begin
        if (tick_s && rx_s) begin
          state_n = ST_IDLE;
        end else begin
          state_n = ST_WAIT_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Per-frame datapath: latched mode, data shifter, parity capture.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      mode_r    <= PAR_NONE;
      shreg_r   <= '0;
      bit_cnt_r <= '0;
      par_bit_r <= 1'b0;
      par_err_r <= 1'b0;
    end else if (start_s) begin
      mode_r    <= ParityMode;
      shreg_r   <= '0;
      bit_cnt_r <= '0;
      par_bit_r <= 1'b0;
      par_err_r <= 1'b0;
    end else if (decide_s) begin
      case (state_r)
        ST_DATA: begin
          shreg_r   <= {vote_s, shreg_r[Width-1:1]};
          bit_cnt_r <= bit_cnt_r + 4'd1;
        end
        ST_PARITY: begin
          par_bit_r <= vote_s;
          par_err_r <= vote_s ^ parity_expected(mode_r, push_entry_s.data);
        end
        default: begin
          par_bit_r <= par_bit_r;
        end
      endcase
    end
  end

  // Sticky overrun (a new overrun beats a clear) and registered break pulse.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      overrun_r <= 1'b0;
      break_r   <= 1'b0;
    end else begin
      break_r <= break_s;
      if (overrun_set_s) begin
        overrun_r <= 1'b1;
      end else if (ClearOverrun) begin
        overrun_r <= 1'b0;
      end
    end
  end

`ifdef UARX_FIFO_EN
  uarx_fifo #(
    .EntryW ($bits(uarx_entry_t)),
    .Depth  (FifoDepth),
    .CW     (FCWidth)
  ) u_fifo (
    .clk     (Clock),
    .rst     (Reset),
    .wr_en   (push_s),
    .wr_data (push_entry_s),
    .rd_en   (pop_s),
    .rd_data (head_s),
    .count   (count_s),
    .full    (full_s),
    .empty   (empty_s)
  );
`else
  uarx_entry_t hold_r;
  logic        hold_valid_r;

  // Single holding register; a push while full is taken only alongside a pop.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      hold_r       <= '0;
      hold_valid_r <= 1'b0;
    end else if (push_s && (!hold_valid_r || pop_s)) begin
      hold_r       <= push_entry_s;
      hold_valid_r <= 1'b1;
    end else if (pop_s) begin
      hold_valid_r <= 1'b0;
    end
  end

  assign head_s  = hold_valid_r ? hold_r : '0;
  assign full_s  = hold_valid_r;
  assign empty_s = ~hold_valid_r;
  assign count_s = FCWidth'(hold_valid_r);
`endif

  assign DataOut           = head_s.data[Width-1:0];
  assign DataOutFramingErr = head_s.framing_err;
  assign DataOutParityErr  = head_s.parity_err;
  assign DataOutValid      = ~empty_s;
  assign FifoCount         = count_s;
  assign Overrun           = overrun_r;
  assign BreakDetect       = break_r;

  // Padding bits above Width are always zero.
  assign unused_s = ^head_s;

endmodule
